// File: rtl/arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks (serial adder,
// serial subtractor and later members of the family).
//   arith_state_e : handshake FSM states (idle / run / done)
//   BIT32_WIDTH   : default operand width
//   BIT32_STEP    : default number of bits processed per RUN cycle
package arith_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } arith_state_e;

  localparam int unsigned BIT32_WIDTH = 32;
  localparam int unsigned BIT32_STEP  = 4;

endpackage

// File: rtl/bit_step_adder.sv
// Combinational Width-bit ripple-carry adder built from a chain of full adders.
// Ports:
//   a_i, b_i : addend slices
//   cin_i    : carry into bit 0
//   s_o      : slice sum
//   co_o     : carry out of bit Width-1
module bit_step_adder #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width-1:0] s_o,
  output logic             co_o
);

  logic [Width:0] carry;

  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = cin_i;
    for (int i = 0; i < int'(Width); i++) begin
      s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign co_o = carry[Width];

endmodule

// File: rtl/bit_32_serial_adder.sv
// Multi-cycle adder: adds STEP bits per clock under a start/busy/done handshake.
// Operands are captured when start is accepted (IDLE or DONE); the result is held
// from the first done cycle until the next accepted start or reset.
// Ports:
//   clk_i   : rising-edge clock
//   rst_ni  : synchronous active-low reset
//   start_i : request, accepted only when not running
//   a_i,b_i : addends, sampled on the accepting edge only
//   busy_o  : high throughout RUN
//   done_o  : one-cycle pulse in DONE
//   sum_o   : a+b modulo 2^WIDTH
//   cout_o  : unsigned carry out of the MSB
//   ovf_o   : signed overflow
module bit_32_serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = BIT32_WIDTH,
  parameter int unsigned STEP  = BIT32_STEP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned NumSlices = WIDTH / STEP;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  typedef logic [CntW-1:0] cnt_t;

  if ((WIDTH % STEP) != 0) begin : g_bad_step
    $error("bit_32_serial_adder: WIDTH must be a multiple of STEP");
  end

  arith_state_e     state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last_slice;
  int unsigned      base;
  logic [STEP-1:0]  a_slice, b_slice, slice_s;
  logic             slice_co;

  assign accept     = start_i && (state_q != StRun);
  assign last_slice = (cnt_q == cnt_t'(NumSlices - 1));
  assign base       = int'(cnt_q) * STEP;
  assign a_slice    = a_q[base +: STEP];
  assign b_slice    = b_q[base +: STEP];

  bit_step_adder #(
    .Width (STEP)
  ) u_step_adder (
    .a_i   (a_slice),
    .b_i   (b_slice),
    .cin_i (carry_q),
    .s_o   (slice_s),
    .co_o  (slice_co)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (last_slice) state_d = StDone;
      StDone:  state_d = start_i ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: everything comes straight from registers
  always_comb begin
    busy_o = (state_q == StRun);
    done_o = (state_q == StDone);
    sum_o  = sum_q;
    cout_o = cout_q;
    ovf_o  = ovf_q;
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = a_i;
      b_d     = b_i;
      sum_d   = '0;
      carry_d = 1'b0;
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      sum_d[base +: STEP] = slice_s;
      carry_d             = slice_co;
      cnt_d               = cnt_q + cnt_t'(1);
      if (last_slice) begin
        cout_d = slice_co;
        // slice_s[STEP-1] is the new sum MSB on the final slice
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[STEP-1] != a_q[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
